sha256_block_engine: RTL and testbench
======================================

# sha256_block_engine

Parametrised successor to the single-round SHA-256 hash core: a complete SHA-224/SHA-256 compression engine. It accepts whole 512-bit padded message blocks over a valid/ready handshake, expands the message schedule internally, and runs R rounds per clock. It chains intermediate hash state across multi-block messages and presents the digest over a second valid/ready handshake. It sits between the padding/framing front end and the result sink; there is no external message scheduler or constant ROM.

## Interface
- ROUNDS_PER_CYCLE, default 1: rounds unrolled per clock (R). Legal values are 1, 2, 4, 8; anything else is an elaboration error.
- clk  in  1  sole clock; all logic on the rising edge.
- rst  in  1  synchronous reset, active-high.
- blk_valid  in  1  a block is offered.
- blk_ready  out  1  engine can accept a block; high only in IDLE.
- blk_data  in  512  padded block; word W0 = [511:480], W15 = [31:0].
- blk_first  in  1  first block of a message; loads the IV for the selected mode.
- blk_last  in  1  last block of a message; produces a digest.
- mode_224  in  1  1 = SHA-224, 0 = SHA-256. Sampled only on an accepted blk_first block.
- dig_valid  out  1  digest is held and valid.
- dig_ready  in  1  sink accepts the digest.
- digest  out  256  H0..H7 with H0 at [255:224]. In SHA-224 mode [31:0] is forced to 0.
- busy  out  1  high in any state other than IDLE.

## Operation
- States and transitions:
  - IDLE → ROUND on blk_valid && blk_ready.
  - ROUND → FINAL when the round counter completes its last step.
  - FINAL → OUT if the block had blk_last; otherwise FINAL → IDLE.
  - OUT → IDLE on dig_valid && dig_ready.
- Accept edge:
  - Latch blk_data into the 16-word schedule window.
  - Latch blk_last.
  - If blk_first: load H0..H7 and a..h with the IV of mode_224, and latch the mode.
  - Otherwise: load a..h from the current H0..H7.
- ROUND: each cycle applies R sequential rounds t..t+R-1 using K[t] and W[t].
  - For t<16, W[t] comes from the window. For t≥16, W[t] = σ1(W[t-2]) + W[t-7] + σ0(W[t-15]) + W[t-16].
  - The window shifts by R words per cycle.
  - The round counter is 6 bits, steps by R, and the last step is at t = 64−R.
- FINAL: Hi ← Hi + working variable i (mod 2^32). If blk_last, also register digest from the new H values (SHA-224 truncation applies).
- All additions are modulo 2^32; carries are discarded.
- The engine never accepts a block in ROUND, FINAL or OUT.
- A non-first block with no prior chain since reset chains from the SHA-256 IV, which is the reset value of H; this is deterministic, with no error flag.
- mode_224 on non-first blocks is ignored; the latched mode persists until the next blk_first.
- blk_first and blk_last may both be set (single-block message).

## Timing
- Reset values: blk_ready=1, dig_valid=0, busy=0, digest=0. State = IDLE, H0..H7 = SHA-256 IV, latched mode = SHA-256, round counter = 0.
- Reset asserted mid-block or mid-OUT abandons all work: no digest, and the chain returns to the SHA-256 IV.
- With the accept on edge 0:
  - Rounds occur on edges 1..64/R.
  - FINAL completes on edge 64/R+1.
  - dig_valid (or blk_ready for a non-last block) is high in the following cycle.
  - For R=1, accept to dig_valid is 65 cycles; block-to-block accept spacing is 66 cycles.
- dig_valid stays high and digest stays stable until dig_ready is sampled high. blk_ready goes high in the cycle after the digest handshake.
- dig_ready high before dig_valid has no effect.
- busy = !blk_ready.

## Structure
- Package sha2_pkg holds:
  - the K[0:63] constant array;
  - the SHA-224 and SHA-256 IV arrays;
  - Σ0, Σ1, σ0, σ1, Ch and Maj functions;
  - the state enum {IDLE, ROUND, FINAL, OUT}.
- Sub-module sha2_round: one combinational round. It takes a..h, Kt and Wt and returns the next a..h. It is instantiated R times in a generate chain.
- Schedule expansion, the counter, the FSM and the chaining registers live in the top module.

## Test plan
- "abc" single block, SHA-256, R=1. Block is 61626380, then 14×0, then 00000018. Required digest: ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad. dig_valid must rise exactly 65 cycles after the accept.
- Same "abc" block with mode_224=1. Required digest: 23097d22 3405d822 8642a477 bda255b3 2aadbce4 bda0b3f7 e36c9da7 00000000.
- 448-bit message "abcdbcde…nopq" as two blocks (first, then last), swept over R = 1, 2, 4, 8.
  - Required digest: 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1.
  - Latency must be 64/R+1 cycles per block.
- Empty message (block 80000000 followed by zeros), with dig_ready held low for 20 cycles.
  - Digest stays e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855.
  - blk_ready stays 0 and blk_valid is ignored until the digest handshake.
- Reset pulse mid-ROUND of a multi-block message.
  - All outputs return to reset values.
  - A following "abc" block sent with blk_first=0 yields the SHA-256 "abc" digest.
- Back-to-back "abc" messages with blk_valid held high. Each must be accepted in the cycle after the preceding digest handshake, and both digests must be correct.

Source files
------------

// File: rtl/sha2_pkg.sv
// SHA-2 (224/256) constants, round primitives and shared types for the block engine.
package sha2_pkg;

   typedef enum logic [1:0] {IDLE, ROUND, FINAL, OUT} state_t;

   typedef struct packed {
      logic [31:0] a, b, c, d, e, f, g, h;
   } work_t;

   // Message schedule window; element 0 is the oldest word and sits at the MSB end.
   typedef logic [0:15][31:0] win_t;

   localparam logic [31:0] K [0:63] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   localparam logic [31:0] IV_256 [0:7] = '{
      32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
      32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
   };

   localparam logic [31:0] IV_224 [0:7] = '{
      32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
      32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4
   };

   function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [31:0] big_sigma0(input logic [31:0] x);
      return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
   endfunction

   function automatic logic [31:0] big_sigma1(input logic [31:0] x);
      return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
   endfunction

   function automatic logic [31:0] small_sigma0(input logic [31:0] x);
      return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
   endfunction

   function automatic logic [31:0] small_sigma1(input logic [31:0] x);
      return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
   endfunction

   function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
      return (x & y) ^ (~x & z);
   endfunction

   function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
      return (x & y) ^ (x & z) ^ (y & z);
   endfunction

   function automatic work_t iv_state(input logic mode_224);
      if (mode_224)
         return {IV_224[0], IV_224[1], IV_224[2], IV_224[3], IV_224[4], IV_224[5], IV_224[6], IV_224[7]};
      return {IV_256[0], IV_256[1], IV_256[2], IV_256[3], IV_256[4], IV_256[5], IV_256[6], IV_256[7]};
   endfunction

   function automatic work_t add_work(input work_t x, input work_t y);
      work_t z;
      z = '0;
      for (int i = 0; i < 8; i++)
         z[255-32*i -: 32] = x[255-32*i -: 32] + y[255-32*i -: 32];
      return z;
   endfunction

   // Extends the window by r words and returns it advanced by r positions.
   function automatic win_t expand(input win_t w, input int r);
      logic [31:0] ext [0:23];
      win_t        res;
      for (int i = 0; i < 16; i++)
         ext[i] = w[i];
      for (int i = 16; i < 24; i++)
         ext[i] = small_sigma1(ext[i-2]) + ext[i-7] + small_sigma0(ext[i-15]) + ext[i-16];
      for (int i = 0; i < 16; i++)
         res[i] = ext[i + r];
      return res;
   endfunction

endpackage

// File: rtl/sha2_round.sv
// One combinational SHA-2 compression round: a..h, Kt, Wt in, next a..h out.
module sha2_round
   import sha2_pkg::*;
(
   input  work_t       i_state,
   input  logic [31:0] i_kt,
   input  logic [31:0] i_wt,
   output work_t       o_state
);

   logic [31:0] w_t1;
   logic [31:0] w_t2;

   assign w_t1 = i_state.h + big_sigma1(i_state.e) + ch(i_state.e, i_state.f, i_state.g) + i_kt + i_wt;
   assign w_t2 = big_sigma0(i_state.a) + maj(i_state.a, i_state.b, i_state.c);

   assign o_state = {w_t1 + w_t2, i_state.a, i_state.b, i_state.c,
                     i_state.d + w_t1, i_state.e, i_state.f, i_state.g};

endmodule

// File: rtl/sha256_block_engine.sv
// SHA-224/SHA-256 block compression engine: R unrolled rounds per clock,
// internal schedule expansion, multi-block chaining and a held digest output.
//
// state | meaning
// IDLE  | waiting for a block; only state that accepts one
// ROUND | R rounds per cycle, schedule window shifts by R words
// FINAL | fold working variables into H; capture digest on last block
// OUT   | digest held until the sink takes it
module sha256_block_engine
   import sha2_pkg::*;
#(
   parameter int ROUNDS_PER_CYCLE = 1
)
(
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_blk_valid,
   output logic         o_blk_ready,
   input  logic [511:0] i_blk_data,
   input  logic         i_blk_first,
   input  logic         i_blk_last,
   input  logic         i_mode_224,
   output logic         o_dig_valid,
   input  logic         i_dig_ready,
   output logic [255:0] o_digest,
   output logic         o_busy
);

   localparam int         R      = ROUNDS_PER_CYCLE;
   localparam logic [5:0] T_LAST = 6'(64 - R);
   localparam logic [5:0] T_STEP = 6'(R);

   if (!(R == 1 || R == 2 || R == 4 || R == 8)) begin : g_bad_r
      $error("ROUNDS_PER_CYCLE must be 1, 2, 4 or 8");
   end

   state_t       r_state;
   state_t       w_state_nxt;
   work_t        r_h;
   work_t        r_work;
   work_t        w_round_out;
   work_t        w_h_sum;
   win_t         r_w;
   logic [5:0]   r_t;
   logic         r_last;
   logic         r_mode;
   logic [255:0] r_digest;
   logic         w_accept;
   logic         w_t_last;

   assign w_accept = i_blk_valid && o_blk_ready;
   assign w_t_last = (r_t == T_LAST);
   assign w_h_sum  = add_work(r_h, r_work);

   for (genvar j = 0; j < R; j++) begin : g_rnd
      work_t w_in;
      work_t w_out;
      if (j == 0) begin : g_head
         assign w_in = r_work;
      end else begin : g_link
         assign w_in = g_rnd[j-1].w_out;
      end
      sha2_round u_round (
         .i_state (w_in),
         .i_kt    (K[r_t + 6'(j)]),
         .i_wt    (r_w[j]),
         .o_state (w_out)
      );
   end
   assign w_round_out = g_rnd[R-1].w_out;

   always_ff @(posedge i_clk) begin
      if (i_rst) r_state <= IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (w_accept) w_state_nxt = ROUND;
         ROUND:   if (w_t_last) w_state_nxt = FINAL;
         FINAL:   w_state_nxt = r_last ? OUT : IDLE;
         OUT:     if (i_dig_ready) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_comb begin
      o_blk_ready = (r_state == IDLE);
      o_dig_valid = (r_state == OUT);
      o_busy      = (r_state != IDLE);
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_h      <= iv_state(1'b0);
         r_work   <= '0;
         r_w      <= '0;
         r_t      <= '0;
         r_last   <= 1'b0;
         r_mode   <= 1'b0;
         r_digest <= '0;
      end else begin
         case (r_state)
            IDLE: if (w_accept) begin
               r_w    <= win_t'(i_blk_data);
               r_last <= i_blk_last;
               r_t    <= '0;
               if (i_blk_first) begin
                  r_h    <= iv_state(i_mode_224);
                  r_work <= iv_state(i_mode_224);
                  r_mode <= i_mode_224;
               end else begin
                  r_work <= r_h;
               end
            end
            ROUND: begin
               r_work <= w_round_out;
               r_w    <= expand(r_w, R);
               r_t    <= r_t + T_STEP;
            end
            FINAL: begin
               r_h <= w_h_sum;
               if (r_last)
                  r_digest <= r_mode ? {w_h_sum[255:32], 32'h0} : w_h_sum;
            end
            default: ;
         endcase
      end
   end

   assign o_digest = r_digest;

endmodule

// File: tb/tb_sha256_block_engine.sv
// Directed bench for sha256_block_engine: R=1 instance for the main sequence,
// plus R=2/4/8 instances for the two-block latency sweep.
module tb_sha256_block_engine;

   localparam logic [511:0] BLK_ABC   = {32'h61626380, 448'h0, 32'h00000018};
   localparam logic [511:0] BLK_EMPTY = {32'h80000000, 480'h0};
   localparam logic [511:0] BLK_2A    = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                         32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                         32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                         32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
   localparam logic [511:0] BLK_2B    = {480'h0, 32'h000001c0};

   localparam logic [255:0] DIG_ABC256 = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
   localparam logic [255:0] DIG_ABC224 = 256'h23097d223405d8228642a477bda255b32aadbce4bda0b3f7e36c9da700000000;
   localparam logic [255:0] DIG_TWO    = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
   localparam logic [255:0] DIG_EMPTY  = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;

   logic         clk = 1'b0;
   logic         rst;
   logic         blk_valid [4];
   logic         blk_ready [4];
   logic [511:0] blk_data  [4];
   logic         blk_first [4];
   logic         blk_last  [4];
   logic         mode_224  [4];
   logic         dig_valid [4];
   logic         dig_ready [4];
   logic [255:0] digest    [4];
   logic         busy      [4];

   int cyc = 0;
   int n_assert = 0;
   int n_fail = 0;
   logic [255:0] exp_q [$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   for (genvar g = 0; g < 4; g++) begin : g_dut
      sha256_block_engine #(.ROUNDS_PER_CYCLE(1 << g)) u_dut (
         .i_clk       (clk),
         .i_rst       (rst),
         .i_blk_valid (blk_valid[g]),
         .o_blk_ready (blk_ready[g]),
         .i_blk_data  (blk_data[g]),
         .i_blk_first (blk_first[g]),
         .i_blk_last  (blk_last[g]),
         .i_mode_224  (mode_224[g]),
         .o_dig_valid (dig_valid[g]),
         .i_dig_ready (dig_ready[g]),
         .o_digest    (digest[g]),
         .o_busy      (busy[g])
      );
   end

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] expv);
      n_assert++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   task automatic chk_reset(input int k, input string tag);
      chk({tag, "_blk_ready"}, 256'(blk_ready[k]), 256'd1);
      chk({tag, "_dig_valid"}, 256'(dig_valid[k]), 256'd0);
      chk({tag, "_busy"},      256'(busy[k]),      256'd0);
      chk({tag, "_digest"},    digest[k],          256'd0);
   endtask

   // Offers a block and returns the edge count on which it is accepted.
   task automatic send(input int k, input logic [511:0] d, input logic f, input logic l,
                       input logic m, input logic hold, output int acc);
      logic got;
      blk_data[k]  = d;
      blk_first[k] = f;
      blk_last[k]  = l;
      mode_224[k]  = m;
      blk_valid[k] = 1'b1;
      got = 1'b0;
      for (int i = 0; i < 400; i++) begin
         if (blk_ready[k]) begin
            got = 1'b1;
            break;
         end
         @(negedge clk);
      end
      chk("send_timeout", 256'(got), 256'd1);
      acc = cyc + 1;
      @(posedge clk);
      #1;
      if (!hold) blk_valid[k] = 1'b0;
   endtask

   task automatic wait_digest(input int k, input int acc, input int lat, input string tag);
      logic got;
      got = 1'b0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (dig_valid[k]) begin
            got = 1'b1;
            break;
         end
      end
      chk({tag, "_dig_timeout"}, 256'(got), 256'd1);
      chk({tag, "_dig_latency"}, 256'(cyc - acc), 256'(lat));
   endtask

   task automatic wait_ready(input int k, input int acc, input int lat, input string tag);
      logic got;
      got = 1'b0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (blk_ready[k]) begin
            got = 1'b1;
            break;
         end
      end
      chk({tag, "_rdy_timeout"}, 256'(got), 256'd1);
      chk({tag, "_rdy_latency"}, 256'(cyc - acc), 256'(lat));
   endtask

   // Called at a negedge with dig_valid high: checks against the scoreboard, then handshakes.
   task automatic take_digest(input int k, input string tag);
      logic [255:0] expv;
      chk({tag, "_sb_nonempty"}, 256'(exp_q.size() != 0), 256'd1);
      expv = (exp_q.size() != 0) ? exp_q.pop_front() : 256'hx;
      chk({tag, "_digest"}, digest[k], expv);
      dig_ready[k] = 1'b1;
      @(posedge clk);
      #1;
      dig_ready[k] = 1'b0;
      @(negedge clk);
      chk({tag, "_post_dig_valid"}, 256'(dig_valid[k]), 256'd0);
      chk({tag, "_post_blk_ready"}, 256'(blk_ready[k]), 256'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int a1, a2, hs;
      rst = 1'b1;
      for (int k = 0; k < 4; k++) begin
         blk_valid[k] = 1'b0;
         blk_data[k]  = '0;
         blk_first[k] = 1'b0;
         blk_last[k]  = 1'b0;
         mode_224[k]  = 1'b0;
         dig_ready[k] = 1'b0;
      end
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk_reset(0, "reset");
      chk_reset(3, "reset_r8");

      // "abc" SHA-256
      send(0, BLK_ABC, 1'b1, 1'b1, 1'b0, 1'b0, a1);
      exp_q.push_back(DIG_ABC256);
      chk("abc256_busy", 256'(busy[0]), 256'd1);
      wait_digest(0, a1, 65, "abc256");
      take_digest(0, "abc256");

      // "abc" SHA-224, with dig_ready raised early
      send(0, BLK_ABC, 1'b1, 1'b1, 1'b1, 1'b0, a1);
      exp_q.push_back(DIG_ABC224);
      dig_ready[0] = 1'b1;
      wait_digest(0, a1, 65, "abc224");
      take_digest(0, "abc224");

      // empty message, digest held for 20 cycles while a block is offered
      send(0, BLK_EMPTY, 1'b1, 1'b1, 1'b0, 1'b0, a1);
      exp_q.push_back(DIG_EMPTY);
      blk_data[0]  = BLK_ABC;
      blk_valid[0] = 1'b1;
      wait_digest(0, a1, 65, "empty");
      for (int i = 0; i < 20; i++) begin
         chk("empty_hold_digest", digest[0], DIG_EMPTY);
         chk("empty_hold_blk_ready", 256'(blk_ready[0]), 256'd0);
         chk("empty_hold_dig_valid", 256'(dig_valid[0]), 256'd1);
         @(negedge clk);
      end
      blk_valid[0] = 1'b0;
      take_digest(0, "empty");
      @(negedge clk);
      chk("empty_no_accept_busy", 256'(busy[0]), 256'd0);

      // reset mid-ROUND of a two-block message, then non-first "abc" with mode_224 set
      send(0, BLK_2A, 1'b1, 1'b0, 1'b0, 1'b0, a1);
      repeat (20) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk_reset(0, "midreset");
      send(0, BLK_ABC, 1'b0, 1'b1, 1'b1, 1'b0, a1);
      exp_q.push_back(DIG_ABC256);
      wait_digest(0, a1, 65, "postreset");
      take_digest(0, "postreset");

      // back-to-back "abc" with blk_valid held high
      send(0, BLK_ABC, 1'b1, 1'b1, 1'b0, 1'b1, a1);
      exp_q.push_back(DIG_ABC256);
      wait_digest(0, a1, 65, "b2b1");
      chk("b2b1_digest_peek", digest[0], DIG_ABC256);
      exp_q.push_back(DIG_ABC256);
      dig_ready[0] = 1'b1;
      @(posedge clk);
      #1;
      dig_ready[0] = 1'b0;
      hs = cyc;
      void'(exp_q.pop_front());
      @(negedge clk);
      chk("b2b_ready_after_hs", 256'(blk_ready[0]), 256'd1);
      @(posedge clk);
      #1;
      a2 = cyc;
      blk_valid[0] = 1'b0;
      chk("b2b_accept_busy", 256'(busy[0]), 256'd1);
      chk("b2b_accept_gap", 256'(a2 - hs), 256'd1);
      wait_digest(0, a2, 65, "b2b2");
      take_digest(0, "b2b2");

      // two-block 448-bit message swept over R = 1, 2, 4, 8
      for (int k = 0; k < 4; k++) begin
         int r;
         r = 1 << k;
         send(k, BLK_2A, 1'b1, 1'b0, 1'b0, 1'b0, a1);
         wait_ready(k, a1, 64 / r + 1, $sformatf("two_r%0d_blk1", r));
         send(k, BLK_2B, 1'b0, 1'b1, 1'b1, 1'b0, a2);
         chk($sformatf("two_r%0d_spacing", r), 256'(a2 - a1), 256'(64 / r + 2));
         exp_q.push_back(DIG_TWO);
         wait_digest(k, a2, 64 / r + 1, $sformatf("two_r%0d", r));
         take_digest(k, $sformatf("two_r%0d", r));
      end

      chk("sb_drained", 256'(exp_q.size()), 256'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
